// File: rtl/pwm_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_cmd_sequencer
//
// Byte-level command sequencer between the serial front end and the PWM
// register file. The first byte of each frame is a command: bit 7 selects
// write (1) or read (0), bit 6 enables burst auto-increment and the low six
// bits give the start address. The block is the only master of the register
// bus and issues single-cycle read/write pulses. Read data comes back to the
// serial front end as a byte to transmit.
//
// Parameters
//   ADDR_W    register address width
//   DATA_W    byte / register data width
//   READ_LAT  cycles from a read pulse until data_read is valid (>= 1)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous reset, active low
//   frame_active  high while a serial frame is in progress
//   byte_valid    one-cycle strobe, byte_in holds a received byte
//   byte_in       received byte
//   tx_byte       byte to transmit next (read data)
//   tx_load       one-cycle strobe, tx_byte is valid
//   read          register-bus read pulse
//   write         register-bus write pulse
//   addr          register-bus address
//   data_write    register-bus write data
//   data_read     register-bus read data, valid READ_LAT cycles after read
//   overrun       sticky flag, a byte arrived while a read was in flight
// ---------------------------------------------------------------------------
module pwm_cmd_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_active,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_in,
    output logic [DATA_W-1:0] tx_byte,
    output logic              tx_load,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output logic              overrun
);

    localparam int CNT_W = $clog2(READ_LAT + 2);

    typedef enum logic [2:0] {
        S_CMD,
        S_WDATA,
        S_RWAIT,
        S_RNEXT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              burst_q, burst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              read_d, write_d, tx_load_d, overrun_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_write_d, tx_byte_d;

    logic lat_done;

    // The read wait ends on the edge where the counter has seen READ_LAT
    // edges since the read pulse was issued.
    assign lat_done = (cnt_q == CNT_W'(READ_LAT));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Frame end wins over everything so that an aborted
    // frame always restarts at the command byte.
    always_comb begin
        state_d = state_q;
        if (!frame_active) begin
            state_d = S_CMD;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (byte_valid) begin
                        state_d = byte_in[DATA_W-1] ? S_WDATA : S_RWAIT;
                    end
                end
                S_WDATA: begin
                    if (byte_valid && !burst_q) begin
                        state_d = S_DONE;
                    end
                end
                S_RWAIT: begin
                    if (lat_done) begin
                        state_d = burst_q ? S_RNEXT : S_DONE;
                    end
                end
                S_RNEXT: begin
                    if (byte_valid) begin
                        state_d = S_RWAIT;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_CMD;
            endcase
        end
    end

    // Output and datapath next values. Pulses default low, addr/data hold.
    // With frame_active low nothing is issued, which also drops a byte that
    // lands on the frame-end edge and abandons any pending read capture.
    always_comb begin
        read_d       = 1'b0;
        write_d      = 1'b0;
        tx_load_d    = 1'b0;
        addr_d       = addr;
        data_write_d = data_write;
        tx_byte_d    = tx_byte;
        overrun_d    = overrun;
        cur_addr_d   = cur_addr_q;
        burst_d      = burst_q;
        cnt_d        = cnt_q;
        if (frame_active) begin
            case (state_q)
                S_CMD: begin
                    if (byte_valid) begin
                        burst_d    = byte_in[DATA_W-2];
                        cur_addr_d = byte_in[ADDR_W-1:0];
                        if (!byte_in[DATA_W-1]) begin
                            read_d = 1'b1;
                            addr_d = byte_in[ADDR_W-1:0];
                            cnt_d  = '0;
                        end
                    end
                end
                S_WDATA: begin
                    if (byte_valid) begin
                        write_d      = 1'b1;
                        addr_d       = cur_addr_q;
                        data_write_d = byte_in;
                        if (burst_q) begin
                            cur_addr_d = cur_addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_RWAIT: begin
                    if (byte_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (lat_done) begin
                        tx_byte_d = data_read;
                        tx_load_d = 1'b1;
                        if (burst_q) begin
                            cur_addr_d = cur_addr_q + ADDR_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RNEXT: begin
                    if (byte_valid) begin
                        read_d = 1'b1;
                        addr_d = cur_addr_q;
                        cnt_d  = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs and datapath state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read       <= 1'b0;
            write      <= 1'b0;
            tx_load    <= 1'b0;
            addr       <= '0;
            data_write <= '0;
            tx_byte    <= '0;
            overrun    <= 1'b0;
            cur_addr_q <= '0;
            burst_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            read       <= read_d;
            write      <= write_d;
            tx_load    <= tx_load_d;
            addr       <= addr_d;
            data_write <= data_write_d;
            tx_byte    <= tx_byte_d;
            overrun    <= overrun_d;
            cur_addr_q <= cur_addr_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_cmd_sequencer
//
// Scoreboard bench for pwm_cmd_sequencer. Expected register-bus pulses and
// transmit bytes (with the cycle they should appear in) are queued as bytes
// are driven, and a monitor pops and compares them when the DUT pulses.
// A small register-file model answers reads after READ_LAT cycles.
// ---------------------------------------------------------------------------
module tb_pwm_cmd_sequencer;

    localparam int RL = 3;

    logic       clk;
    logic       rst_n;
    logic       frame_active;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       overrun;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        int         cyc;
        logic [5:0] addr;
        logic [7:0] val;
    } ev_t;

    ev_t wq[$];
    ev_t rq[$];
    ev_t tq[$];

    logic [7:0] rdPipe [RL];

    pwm_cmd_sequencer #(
        .ADDR_W  (6),
        .DATA_W  (8),
        .READ_LAT(RL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_active(frame_active),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .tx_byte     (tx_byte),
        .tx_load     (tx_load),
        .read        (read),
        .write       (write),
        .addr        (addr),
        .data_write  (data_write),
        .data_read   (data_read),
        .overrun     (overrun)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after rising edge k the counter reads k
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Register-file read data: address 0x08 holds 0xCD, every other address
    // returns its address inverted
    function automatic logic [7:0] regModel(input logic [5:0] a);
        if (a == 6'h08) begin
            return 8'hCD;
        end
        return {2'b00, a} ^ 8'hFF;
    endfunction

    // Register-file read pipeline: data is valid only on the edge READ_LAT
    // cycles after the read pulse was sampled
    always @(posedge clk) begin
        rdPipe[0] <= read ? regModel(addr) : 8'h00;
        for (int i = 1; i < RL; i++) begin
            rdPipe[i] <= rdPipe[i-1];
        end
    end
    assign data_read = rdPipe[RL-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops expected events when the DUT pulses
    always @(negedge clk) begin
        ev_t e;
        if (write) begin
            if (wq.size() == 0) begin
                checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = wq.pop_front();
                checkOutput("write_cycle", cyc, e.cyc);
                checkOutput("write_addr", {26'd0, addr}, {26'd0, e.addr});
                checkOutput("write_data", {24'd0, data_write}, {24'd0, e.val});
            end
        end
        if (read) begin
            if (rq.size() == 0) begin
                checkOutput("unexpected_read", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                checkOutput("read_cycle", cyc, e.cyc);
                checkOutput("read_addr", {26'd0, addr}, {26'd0, e.addr});
            end
        end
        if (tx_load) begin
            if (tq.size() == 0) begin
                checkOutput("unexpected_tx_load", 32'd1, 32'd0);
            end else begin
                e = tq.pop_front();
                checkOutput("tx_cycle", cyc, e.cyc);
                checkOutput("tx_byte", {24'd0, tx_byte}, {24'd0, e.val});
            end
        end
    end

    task automatic expectWrite(input int c, input logic [5:0] a, input logic [7:0] d);
        ev_t e;
        e.cyc = c; e.addr = a; e.val = d;
        wq.push_back(e);
    endtask

    task automatic expectRead(input int c, input logic [5:0] a);
        ev_t e;
        e.cyc = c; e.addr = a; e.val = 8'h00;
        rq.push_back(e);
        e.cyc = c + 1 + RL; e.val = regModel(a);
        tq.push_back(e);
    endtask

    task automatic expectReadNoData(input int c, input logic [5:0] a);
        ev_t e;
        e.cyc = c; e.addr = a; e.val = 8'h00;
        rq.push_back(e);
    endtask

    // Drives one byte strobe and returns the edge that samples it; returns
    // just after that edge so expectations are queued before the monitor runs
    task automatic applyStimulus(input logic [7:0] b, output int edgeNum);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        edgeNum    = cyc + 1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic startFrame();
        @(negedge clk);
        frame_active = 1'b1;
    endtask

    task automatic endFrame();
        @(negedge clk);
        frame_active = 1'b0;
        idle(2);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_read"}, {31'd0, read}, 32'd0);
        checkOutput({tag, "_write"}, {31'd0, write}, 32'd0);
        checkOutput({tag, "_tx_load"}, {31'd0, tx_load}, 32'd0);
        checkOutput({tag, "_addr"}, {26'd0, addr}, 32'd0);
        checkOutput({tag, "_data_write"}, {24'd0, data_write}, 32'd0);
        checkOutput({tag, "_tx_byte"}, {24'd0, tx_byte}, 32'd0);
        checkOutput({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        int e;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        frame_active = 1'b0;
        byte_valid   = 1'b0;
        byte_in      = 8'h00;
        idle(3);
        checkAllZero("reset");
        rst_n = 1'b1;
        idle(2);

        // Single write, then a trailing byte that must be ignored
        startFrame();
        applyStimulus(8'h80, e);
        applyStimulus(8'h34, e);
        expectWrite(e, 6'h00, 8'h34);
        applyStimulus(8'h99, e);
        idle(3);
        endFrame();

        // Burst write
        startFrame();
        applyStimulus(8'hC3, e);
        applyStimulus(8'hAA, e);
        expectWrite(e, 6'h03, 8'hAA);
        applyStimulus(8'h55, e);
        expectWrite(e, 6'h04, 8'h55);
        idle(2);
        endFrame();

        // Burst write wrapping from the top address
        startFrame();
        applyStimulus(8'hFF, e);
        applyStimulus(8'h01, e);
        expectWrite(e, 6'h3F, 8'h01);
        applyStimulus(8'h02, e);
        expectWrite(e, 6'h00, 8'h02);
        idle(2);
        endFrame();

        // Single read
        startFrame();
        applyStimulus(8'h08, e);
        expectRead(e, 6'h08);
        idle(RL + 4);
        endFrame();

        // Burst read with wrap and two dummy bytes
        startFrame();
        applyStimulus(8'h7F, e);
        expectRead(e, 6'h3F);
        idle(RL + 2);
        applyStimulus(8'h00, e);
        expectRead(e, 6'h00);
        idle(RL + 2);
        applyStimulus(8'h5A, e);
        expectRead(e, 6'h01);
        idle(RL + 3);
        endFrame();

        // Aborted write: frame ends with a data byte on the same edge
        startFrame();
        applyStimulus(8'h80, e);
        @(negedge clk);
        frame_active = 1'b0;
        byte_in      = 8'h34;
        byte_valid   = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        idle(2);
        startFrame();
        applyStimulus(8'h82, e);
        applyStimulus(8'h11, e);
        expectWrite(e, 6'h02, 8'h11);
        idle(2);
        endFrame();

        // Aborted read: frame ends before the capture, no tx_load
        startFrame();
        applyStimulus(8'h09, e);
        expectReadNoData(e, 6'h09);
        @(negedge clk);
        frame_active = 1'b0;
        idle(RL + 4);

        // Byte during the read wait is dropped and sets overrun
        checkOutput("overrun_clear", {31'd0, overrun}, 32'd0);
        startFrame();
        applyStimulus(8'h45, e);
        expectRead(e, 6'h05);
        applyStimulus(8'h99, e);
        idle(RL + 2);
        checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
        applyStimulus(8'h00, e);
        expectRead(e, 6'h06);
        idle(RL + 3);
        endFrame();
        checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a burst write
        startFrame();
        applyStimulus(8'hC0, e);
        applyStimulus(8'h11, e);
        expectWrite(e, 6'h00, 8'h11);
        applyStimulus(8'h22, e);
        expectWrite(e, 6'h01, 8'h22);
        @(negedge clk);
        rst_n      = 1'b0;
        byte_in    = 8'h33;
        byte_valid = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        byte_valid = 1'b0;
        rst_n      = 1'b1;
        endFrame();
        startFrame();
        applyStimulus(8'h81, e);
        applyStimulus(8'h77, e);
        expectWrite(e, 6'h01, 8'h77);
        idle(3);
        endFrame();

        idle(RL + 4);
        checkOutput("writes_left", wq.size(), 32'd0);
        checkOutput("reads_left", rq.size(), 32'd0);
        checkOutput("tx_left", tq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
